// File: rtl/noc_arb_pkg.sv
// Shared definitions for the router output-port arbiter: port indices,
// select encodings, FSM state type and grant-vector conversion helpers.
package noc_arb_pkg;

   localparam int NUM_PORTS = 5;
   localparam int SEL_W     = 3;

   localparam logic [SEL_W-1:0] IDLE_SEL = 3'b111;

   localparam logic [SEL_W-1:0] PORT_N = 3'd0;
   localparam logic [SEL_W-1:0] PORT_S = 3'd1;
   localparam logic [SEL_W-1:0] PORT_W = 3'd2;
   localparam logic [SEL_W-1:0] PORT_E = 3'd3;
   localparam logic [SEL_W-1:0] PORT_L = 3'd4;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   // Request/grant vectors are MSB-first: bit4=N ... bit0=L, so index i lives at bit 4-i.
   function automatic logic [NUM_PORTS-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_PORTS-1:0] oh;
      case (idx)
         PORT_N:  oh = 5'b10000;
         PORT_S:  oh = 5'b01000;
         PORT_W:  oh = 5'b00100;
         PORT_E:  oh = 5'b00010;
         PORT_L:  oh = 5'b00001;
         default: oh = 5'b10000;
      endcase
      return oh;
   endfunction

   function automatic logic [SEL_W-1:0] onehot2idx(input logic [NUM_PORTS-1:0] oh);
      logic [SEL_W-1:0] idx;
      case (oh)
         5'b10000: idx = PORT_N;
         5'b01000: idx = PORT_S;
         5'b00100: idx = PORT_W;
         5'b00010: idx = PORT_E;
         5'b00001: idx = PORT_L;
         default:  idx = PORT_N;
      endcase
      return idx;
   endfunction

   function automatic logic [SEL_W-1:0] add_mod5(input logic [SEL_W-1:0] a,
                                                 input logic [SEL_W-1:0] b);
      logic [SEL_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 4'd5) s = s - 4'd5;
      return s[SEL_W-1:0];
   endfunction

endpackage

// File: rtl/rr_rotate_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at position 0,
// take the first set position, and map it back to an absolute port index.
module rr_rotate_pick
   import noc_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [SEL_W-1:0]     ptr,
   output logic                 found,
   output logic [SEL_W-1:0]     win_idx
);

   logic [SEL_W-1:0]     base;
   logic [SEL_W-1:0]     k_sel;
   logic [NUM_PORTS-1:0] req_idx;
   logic [NUM_PORTS-1:0] rot;

   always_comb begin
      // Out-of-range pointer values behave as N.
      base = (ptr > PORT_L) ? PORT_N : ptr;
      for (int i = 0; i < NUM_PORTS; i++) req_idx[i] = req[NUM_PORTS-1-i];
      for (int k = 0; k < NUM_PORTS; k++) rot[k] = req_idx[add_mod5(base, k[SEL_W-1:0])];
      found = |rot;
      k_sel = '0;
      for (int k = NUM_PORTS-1; k >= 0; k--) begin
         if (rot[k]) k_sel = k[SEL_W-1:0];
      end
      win_idx = add_mod5(base, k_sel);
   end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin wormhole grant controller for one 5-input router output port.
// A granted input owns the output until its tail flit transfers; release re-arbitrates with no bubble.
module rr_grant_ctrl
   import noc_arb_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [NUM_PORTS-1:0] tail_i,
   input  logic                 out_ready_i,
   output logic [NUM_PORTS-1:0] grant_o,
   output logic                 grant_valid_o,
   output logic [SEL_W-1:0]     cs_sel_o,
   output logic                 xfer_o
);

   arb_state_t           state, state_n;
   logic [SEL_W-1:0]     ptr, ptr_n;
   logic [NUM_PORTS-1:0] grant_n;
   logic [SEL_W-1:0]     sel_n;
   logic                 gv_n;

   logic [SEL_W-1:0]     g_idx;
   logic [SEL_W-1:0]     rel_ptr;
   logic [SEL_W-1:0]     pick_ptr;
   logic [NUM_PORTS-1:0] pick_req;
   logic                 pick_found;
   logic [SEL_W-1:0]     pick_idx;
   logic                 rel_evt;

   assign g_idx   = onehot2idx(grant_o);
   assign xfer_o  = grant_valid_o & (|(grant_o & req_i)) & out_ready_i;
   assign rel_evt = xfer_o & (|(grant_o & tail_i));
   assign rel_ptr = add_mod5(g_idx, 3'd1);

   // The releasing input is masked out so it cannot win the same-cycle re-arbitration.
   assign pick_req = (state == ARB_BUSY) ? (req_i & ~grant_o) : req_i;
   assign pick_ptr = rel_evt ? rel_ptr : ptr;

   rr_rotate_pick u_pick (
      .req     (pick_req),
      .ptr     (pick_ptr),
      .found   (pick_found),
      .win_idx (pick_idx)
   );

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      grant_n = grant_o;
      sel_n   = cs_sel_o;
      gv_n    = grant_valid_o;
      case (state)
         ARB_IDLE: begin
            if (pick_found) begin
               state_n = ARB_BUSY;
               grant_n = idx2onehot(pick_idx);
               sel_n   = pick_idx;
               gv_n    = 1'b1;
            end
         end
         ARB_BUSY: begin
            if (rel_evt) begin
               ptr_n = rel_ptr;
               if (pick_found) begin
                  grant_n = idx2onehot(pick_idx);
                  sel_n   = pick_idx;
               end else begin
                  state_n = ARB_IDLE;
                  grant_n = '0;
                  sel_n   = IDLE_SEL;
                  gv_n    = 1'b0;
               end
            end
         end
         default: begin
            state_n = ARB_IDLE;
            grant_n = '0;
            sel_n   = IDLE_SEL;
            gv_n    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= ARB_IDLE;
         ptr           <= PORT_N;
         grant_o       <= '0;
         cs_sel_o      <= IDLE_SEL;
         grant_valid_o <= 1'b0;
      end else begin
         state         <= state_n;
         ptr           <= ptr_n;
         grant_o       <= grant_n;
         cs_sel_o      <= sel_n;
         grant_valid_o <= gv_n;
      end
   end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: reset, single packet, full contention,
// backpressure, requester stall and mid-packet asynchronous reset.
module tb_rr_grant_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b1;
   logic [4:0] req_i = '0;
   logic [4:0] tail_i = '0;
   logic       out_ready_i = 1'b1;
   logic [4:0] grant_o;
   logic       grant_valid_o;
   logic [2:0] cs_sel_o;
   logic       xfer_o;

   int vectors = 0;
   int miscompares = 0;

   rr_grant_ctrl dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .req_i         (req_i),
      .tail_i        (tail_i),
      .out_ready_i   (out_ready_i),
      .grant_o       (grant_o),
      .grant_valid_o (grant_valid_o),
      .cs_sel_o      (cs_sel_o),
      .xfer_o        (xfer_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      req_i = '0; tail_i = '0; out_ready_i = 1'b1;
      step();
      step();
      rst_n_i = 1'b1;
   endtask

   task automatic test_reset();
      req_i = 5'b11111; tail_i = 5'b11111; out_ready_i = 1'b1;
      rst_n_i = 1'b0;
      step();
      step();
      #1;
      vectors++; if (grant_o !== 5'b00000) begin miscompares++; $display("FAIL rst_grant: got %b want 00000", grant_o); end
      vectors++; if (grant_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_gv: got %b want 0", grant_valid_o); end
      vectors++; if (cs_sel_o !== 3'b111) begin miscompares++; $display("FAIL rst_sel: got %b want 111", cs_sel_o); end
      vectors++; if (xfer_o !== 1'b0) begin miscompares++; $display("FAIL rst_xfer: got %b want 0", xfer_o); end
      step();
      rst_n_i = 1'b1;
      #1;
      vectors++; if (grant_o !== 5'b00000) begin miscompares++; $display("FAIL rst_idle_after_release: got %b want 00000", grant_o); end
      step();
      vectors++; if (grant_o !== 5'b10000) begin miscompares++; $display("FAIL rst_first_grant: got %b want 10000", grant_o); end
      vectors++; if (cs_sel_o !== 3'b000) begin miscompares++; $display("FAIL rst_first_sel: got %b want 000", cs_sel_o); end
   endtask

   task automatic test_single_packet();
      int pulses;
      pulses = 0;
      do_reset();
      req_i = 5'b00100; tail_i = '0; out_ready_i = 1'b1;
      #1;
      vectors++; if (grant_o !== 5'b00000) begin miscompares++; $display("FAIL sp_pre_grant: got %b want 00000", grant_o); end
      step();
      vectors++; if (grant_o !== 5'b00100) begin miscompares++; $display("FAIL sp_grant: got %b want 00100", grant_o); end
      vectors++; if (cs_sel_o !== 3'b010) begin miscompares++; $display("FAIL sp_sel: got %b want 010", cs_sel_o); end
      for (int f = 0; f < 3; f++) begin
         if (f == 2) tail_i = 5'b00100;
         #1;
         if (xfer_o === 1'b1) pulses++;
         step();
      end
      vectors++; if (pulses !== 3) begin miscompares++; $display("FAIL sp_pulses: got %0d want 3", pulses); end
      req_i = '0; tail_i = '0;
      #1;
      vectors++; if (grant_o !== 5'b00000) begin miscompares++; $display("FAIL sp_idle_grant: got %b want 00000", grant_o); end
      vectors++; if (grant_valid_o !== 1'b0) begin miscompares++; $display("FAIL sp_idle_gv: got %b want 0", grant_valid_o); end
      vectors++; if (cs_sel_o !== 3'b111) begin miscompares++; $display("FAIL sp_idle_sel: got %b want 111", cs_sel_o); end
      vectors++; if (xfer_o !== 1'b0) begin miscompares++; $display("FAIL sp_idle_xfer: got %b want 0", xfer_o); end
      // N and E request: pointer now at E, so E must beat N.
      req_i = 5'b10010;
      step();
      vectors++; if (grant_o !== 5'b00010) begin miscompares++; $display("FAIL sp_next_from_E: got %b want 00010", grant_o); end
      vectors++; if (cs_sel_o !== 3'b011) begin miscompares++; $display("FAIL sp_next_sel: got %b want 011", cs_sel_o); end
   endtask

   task automatic test_full_contention();
      logic [4:0] exp_g [6];
      logic [2:0] exp_s [6];
      exp_g = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
      exp_s = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      do_reset();
      req_i = 5'b11111; tail_i = 5'b11111; out_ready_i = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         #1;
         vectors++; if (grant_o !== exp_g[i]) begin miscompares++; $display("FAIL fc_grant[%0d]: got %b want %b", i, grant_o, exp_g[i]); end
         vectors++; if (cs_sel_o !== exp_s[i]) begin miscompares++; $display("FAIL fc_sel[%0d]: got %b want %b", i, cs_sel_o, exp_s[i]); end
         vectors++; if (grant_valid_o !== 1'b1) begin miscompares++; $display("FAIL fc_gv[%0d]: got %b want 1", i, grant_valid_o); end
         vectors++; if (xfer_o !== 1'b1) begin miscompares++; $display("FAIL fc_xfer[%0d]: got %b want 1", i, xfer_o); end
         step();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req_i = 5'b00100; tail_i = '0; out_ready_i = 1'b1;
      step();
      step();
      out_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++; if (grant_o !== 5'b00100) begin miscompares++; $display("FAIL bp_grant[%0d]: got %b want 00100", i, grant_o); end
         vectors++; if (cs_sel_o !== 3'b010) begin miscompares++; $display("FAIL bp_sel[%0d]: got %b want 010", i, cs_sel_o); end
         vectors++; if (xfer_o !== 1'b0) begin miscompares++; $display("FAIL bp_xfer[%0d]: got %b want 0", i, xfer_o); end
         step();
      end
      out_ready_i = 1'b1;
      #1;
      vectors++; if (xfer_o !== 1'b1) begin miscompares++; $display("FAIL bp_resume: got %b want 1", xfer_o); end
      step();
      tail_i = 5'b00100;
      #1;
      vectors++; if (xfer_o !== 1'b1) begin miscompares++; $display("FAIL bp_tail_xfer: got %b want 1", xfer_o); end
      step();
      vectors++; if (grant_o !== 5'b00000) begin miscompares++; $display("FAIL bp_released: got %b want 00000", grant_o); end
   endtask

   task automatic test_requester_stall();
      do_reset();
      req_i = 5'b01000; tail_i = '0; out_ready_i = 1'b1;
      step();
      #1;
      vectors++; if (xfer_o !== 1'b1) begin miscompares++; $display("FAIL rs_first_xfer: got %b want 1", xfer_o); end
      step();
      // S drops out while L requests with a tail; L's tail must be ignored.
      req_i = 5'b00001; tail_i = 5'b00001;
      for (int i = 0; i < 2; i++) begin
         #1;
         vectors++; if (grant_o !== 5'b01000) begin miscompares++; $display("FAIL rs_hold[%0d]: got %b want 01000", i, grant_o); end
         vectors++; if (xfer_o !== 1'b0) begin miscompares++; $display("FAIL rs_xfer[%0d]: got %b want 0", i, xfer_o); end
         step();
      end
      req_i = 5'b01001; tail_i = 5'b01000;
      #1;
      vectors++; if (xfer_o !== 1'b1) begin miscompares++; $display("FAIL rs_tail_xfer: got %b want 1", xfer_o); end
      step();
      vectors++; if (grant_o !== 5'b00001) begin miscompares++; $display("FAIL rs_L_grant: got %b want 00001", grant_o); end
      vectors++; if (cs_sel_o !== 3'b100) begin miscompares++; $display("FAIL rs_L_sel: got %b want 100", cs_sel_o); end
      vectors++; if (dut.ptr !== 3'd2) begin miscompares++; $display("FAIL rs_ptr: got %0d want 2", dut.ptr); end
   endtask

   task automatic test_async_reset();
      do_reset();
      req_i = 5'b00010; tail_i = '0; out_ready_i = 1'b1;
      step();
      #1;
      vectors++; if (grant_o !== 5'b00010) begin miscompares++; $display("FAIL ar_grant: got %b want 00010", grant_o); end
      step();
      #1;
      rst_n_i = 1'b0;
      #1;
      vectors++; if (grant_o !== 5'b00000) begin miscompares++; $display("FAIL ar_clr_grant: got %b want 00000", grant_o); end
      vectors++; if (grant_valid_o !== 1'b0) begin miscompares++; $display("FAIL ar_clr_gv: got %b want 0", grant_valid_o); end
      vectors++; if (cs_sel_o !== 3'b111) begin miscompares++; $display("FAIL ar_clr_sel: got %b want 111", cs_sel_o); end
      vectors++; if (xfer_o !== 1'b0) begin miscompares++; $display("FAIL ar_clr_xfer: got %b want 0", xfer_o); end
      step();
      rst_n_i = 1'b1;
      req_i = 5'b00011;
      step();
      vectors++; if (grant_o !== 5'b00010) begin miscompares++; $display("FAIL ar_E_grant: got %b want 00010", grant_o); end
      vectors++; if (cs_sel_o !== 3'b011) begin miscompares++; $display("FAIL ar_E_sel: got %b want 011", cs_sel_o); end
      vectors++; if (dut.ptr !== 3'd0) begin miscompares++; $display("FAIL ar_ptr: got %0d want 0", dut.ptr); end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_full_contention();
      test_backpressure();
      test_requester_stall();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
